// File: rtl/lvds_init_pkg.sv
// Shared types for the LVDS RX power-up/reset sequencer: the state enum, the
// registered output bundle, and the default pulse widths.
package lvds_init_pkg;

  typedef enum logic [2:0] {
    IDLE                 = 3'd0,
    USERMODE             = 3'd1,
    MONITOR              = 3'd2,
    D_RX_RST             = 3'd3,
    WAIT_RX_DPA_LOCK     = 3'd4,
    ASSERT_RX_FIFO_RESET = 3'd5,
    ASSERT_RX_CDA_RESET  = 3'd6,
    DONE                 = 3'd7
  } lvds_init_state_t;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_FIFO_RST_CYCLES = 1;
  localparam int DEF_CDA_RST_CYCLES  = 1;

  typedef struct packed {
    logic pll_areset;
    logic rx_reset;
    logic fifo_reset;
    logic cda_reset;
  } lvds_init_out_t;

  // Output vector owned by each state; IDLE doubles as the reset value.
  function automatic lvds_init_out_t state_outputs(input lvds_init_state_t s);
    lvds_init_out_t o;
    case (s)
      IDLE:                 o = '{1'b1, 1'b1, 1'b0, 1'b0};
      USERMODE, MONITOR:    o = '{1'b0, 1'b1, 1'b0, 1'b0};
      ASSERT_RX_FIFO_RESET: o = '{1'b0, 1'b0, 1'b1, 1'b0};
      ASSERT_RX_CDA_RESET:  o = '{1'b0, 1'b0, 1'b0, 1'b1};
      default:              o = '{1'b0, 1'b0, 1'b0, 1'b0};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/lvds_sync_bit.sv
// Single-bit multi-flop synchronizer for an asynchronous level input; clears
// to 0 on reset so a missing input reads as "not ready".
module lvds_sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  // NOTE: non-blocking assignments make every stage sample the previous
  // stage's old value, giving a true shift chain rather than a wire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/lvds_ip_core_init.sv
// Power-up/reset sequencer for an LVDS SERDES receiver: PLL release, RX reset
// release, DPA lock wait, then FIFO and CDA reset pulses; restarts on loss.
module lvds_ip_core_init
  import lvds_init_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int FIFO_RST_CYCLES = DEF_FIFO_RST_CYCLES,
  parameter int CDA_RST_CYCLES  = DEF_CDA_RST_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic user_mode,
  input  logic rx_locked,
  input  logic rx_dpa_locked,
  output logic pll_areset,
  output logic rx_reset,
  output logic rx_fifo_reset,
  output logic rx_cda_reset
);

  localparam int CNT_MAX = (FIFO_RST_CYCLES > CDA_RST_CYCLES) ? FIFO_RST_CYCLES
                                                              : CDA_RST_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  logic             w_um_s;
  logic             w_lk_s;
  logic             w_dpa_s;
  lvds_init_state_t r_state;
  lvds_init_state_t w_next_state;
  logic [CNT_W-1:0] r_cnt;
  lvds_init_out_t   r_out;
  logic             w_lock_guarded;

  lvds_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_um (
    .clk(clk), .rst_n(rst), .i_d(user_mode), .o_q(w_um_s)
  );

  lvds_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lk (
    .clk(clk), .rst_n(rst), .i_d(rx_locked), .o_q(w_lk_s)
  );

  lvds_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dpa (
    .clk(clk), .rst_n(rst), .i_d(rx_dpa_locked), .o_q(w_dpa_s)
  );

  // States past the PLL lock point fall back to MONITOR when lock drops.
  assign w_lock_guarded = (r_state inside {D_RX_RST, WAIT_RX_DPA_LOCK,
                                           ASSERT_RX_FIFO_RESET,
                                           ASSERT_RX_CDA_RESET, DONE});

  // NOTE: next state defaults to the current state first so every path
  // assigns it and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    if (r_state != IDLE && !w_um_s) begin
      w_next_state = IDLE;
    end else if (w_lock_guarded && !w_lk_s) begin
      w_next_state = MONITOR;
    end else begin
      case (r_state)
        IDLE:             if (w_um_s) w_next_state = USERMODE;
        USERMODE:         w_next_state = MONITOR;
        MONITOR:          if (w_lk_s) w_next_state = D_RX_RST;
        D_RX_RST:         w_next_state = WAIT_RX_DPA_LOCK;
        WAIT_RX_DPA_LOCK: if (w_dpa_s) w_next_state = ASSERT_RX_FIFO_RESET;
        ASSERT_RX_FIFO_RESET:
          if (r_cnt == CNT_W'(FIFO_RST_CYCLES - 1)) w_next_state = ASSERT_RX_CDA_RESET;
        ASSERT_RX_CDA_RESET:
          if (r_cnt == CNT_W'(CDA_RST_CYCLES - 1)) w_next_state = DONE;
        default:          w_next_state = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_out   <= state_outputs(IDLE);
    end else begin
      r_state <= w_next_state;
      // Counter restarts on every state change, so each pulse starts at 0.
      if (w_next_state != r_state) begin
        r_cnt <= '0;
      end else if (r_state inside {ASSERT_RX_FIFO_RESET, ASSERT_RX_CDA_RESET}) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      // Outputs come from the next-state decode so they register glitch-free
      // and line up with the state they belong to.
      r_out <= state_outputs(w_next_state);
    end
  end

  assign pll_areset    = r_out.pll_areset;
  assign rx_reset      = r_out.rx_reset;
  assign rx_fifo_reset = r_out.fifo_reset;
  assign rx_cda_reset  = r_out.cda_reset;

endmodule

// File: tb/tb_lvds_ip_core_init.sv
// Bench for lvds_ip_core_init: two instances (default and widened pulses)
// compared every cycle against a phase/dwell reference model.
module tb_lvds_ip_core_init;

  localparam int SYNC = 2;
  localparam int FA = 1, CA = 1;
  localparam int FB = 4, CB = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic user_mode = 1'b0;
  logic rx_locked = 1'b0;
  logic rx_dpa_locked = 1'b0;

  logic a_pll, a_rx, a_fifo, a_cda;
  logic b_pll, b_rx, b_fifo, b_cda;

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lvds_ip_core_init #(.SYNC_STAGES(SYNC), .FIFO_RST_CYCLES(FA), .CDA_RST_CYCLES(CA)) dut_a (
    .clk(clk), .rst(rst), .user_mode(user_mode), .rx_locked(rx_locked),
    .rx_dpa_locked(rx_dpa_locked), .pll_areset(a_pll), .rx_reset(a_rx),
    .rx_fifo_reset(a_fifo), .rx_cda_reset(a_cda)
  );

  lvds_ip_core_init #(.SYNC_STAGES(SYNC), .FIFO_RST_CYCLES(FB), .CDA_RST_CYCLES(CB)) dut_b (
    .clk(clk), .rst(rst), .user_mode(user_mode), .rx_locked(rx_locked),
    .rx_dpa_locked(rx_dpa_locked), .pll_areset(b_pll), .rx_reset(b_rx),
    .rx_fifo_reset(b_fifo), .rx_cda_reset(b_cda)
  );

  // Reference model: a step number along the bring-up sequence
  // (0 idle .. 7 done) plus the cycles still owed in a pulse step.
  typedef struct {
    int p;
    int d;
  } mstate_t;

  mstate_t ma, mb;
  logic [SYNC-1:0] s_um, s_lk, s_dpa;

  function automatic mstate_t model_step(input mstate_t s, input int nf, input int nc,
                                         input logic um, input logic lk, input logic dpa);
    mstate_t n;
    n = s;
    if (s.p != 0 && !um) begin
      n.p = 0;
    end else if (s.p >= 3 && !lk) begin
      n.p = 2;
    end else begin
      case (s.p)
        0: if (um) n.p = 1;
        1: n.p = 2;
        2: if (lk) n.p = 3;
        3: n.p = 4;
        4: if (dpa) begin n.p = 5; n.d = nf; end
        5: begin
          n.d = s.d - 1;
          if (n.d == 0) begin n.p = 6; n.d = nc; end
        end
        6: begin
          n.d = s.d - 1;
          if (n.d == 0) n.p = 7;
        end
        default: ;
      endcase
    end
    return n;
  endfunction

  // {pll_areset, rx_reset, fifo, cda} implied by a sequence step.
  function automatic logic [3:0] expect_out(input int p);
    return {p == 0, p <= 2, p == 5, p == 6};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ma    <= '{p: 0, d: 0};
      mb    <= '{p: 0, d: 0};
      s_um  <= '0;
      s_lk  <= '0;
      s_dpa <= '0;
    end else begin
      ma    <= model_step(ma, FA, CA, s_um[SYNC-1], s_lk[SYNC-1], s_dpa[SYNC-1]);
      mb    <= model_step(mb, FB, CB, s_um[SYNC-1], s_lk[SYNC-1], s_dpa[SYNC-1]);
      s_um  <= {s_um[SYNC-2:0], user_mode};
      s_lk  <= {s_lk[SYNC-2:0], rx_locked};
      s_dpa <= {s_dpa[SYNC-2:0], rx_dpa_locked};
    end
  end

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    check("a_outputs", {a_pll, a_rx, a_fifo, a_cda}, expect_out(ma.p));
    check("b_outputs", {b_pll, b_rx, b_fifo, b_cda}, expect_out(mb.p));
    check("a_no_overlap", {3'b000, a_fifo & a_cda}, 4'b0000);
    check("b_no_overlap", {3'b000, b_fifo & b_cda}, 4'b0000);
    check("a_rx_vs_pll", {3'b000, a_pll & ~a_rx}, 4'b0000);
    check("b_rx_vs_pll", {3'b000, b_pll & ~b_rx}, 4'b0000);
  end

  initial begin
    // Reset with all inputs low.
    #1 rst = 1'b0;
    #1;
    check("reset_a", {a_pll, a_rx, a_fifo, a_cda}, 4'b1100);
    check("reset_b", {b_pll, b_rx, b_fifo, b_cda}, 4'b1100);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_hold", {a_pll, a_rx, a_fifo, a_cda}, 4'b1100);

    // Nominal bring-up: PLL release lands on the third edge.
    user_mode = 1'b1;
    repeat (2) @(negedge clk);
    check("pll_still_held", {a_pll, a_rx, 2'b00}, 4'b1100);
    @(negedge clk);
    check("pll_released", {a_pll, a_rx, 2'b00}, 4'b0100);
    repeat (4) @(negedge clk);
    rx_locked = 1'b1;
    repeat (6) @(negedge clk);
    check("rx_released", {a_pll, a_rx, a_fifo, a_cda}, 4'b0000);
    rx_dpa_locked = 1'b1;
    repeat (40) @(negedge clk);
    check("done_a", {a_pll, a_rx, a_fifo, a_cda}, 4'b0000);
    check("done_b", {b_pll, b_rx, b_fifo, b_cda}, 4'b0000);

    // Lock loss in DONE, then recovery with pulses replayed.
    rx_locked = 1'b0;
    repeat (3) @(negedge clk);
    check("lock_loss_rx", {a_pll, a_rx, 2'b00}, 4'b0100);
    repeat (3) @(negedge clk);
    rx_locked = 1'b1;
    repeat (30) @(negedge clk);

    // Park in WAIT_RX_DPA_LOCK, then drop user mode.
    rx_dpa_locked = 1'b0;
    rx_locked = 1'b0;
    repeat (6) @(negedge clk);
    rx_locked = 1'b1;
    repeat (8) @(negedge clk);
    check("in_dpa_wait", {b_pll, b_rx, b_fifo, b_cda}, 4'b0000);
    user_mode = 1'b0;
    repeat (3) @(negedge clk);
    check("um_loss_a", {a_pll, a_rx, a_fifo, a_cda}, 4'b1100);
    check("um_loss_b", {b_pll, b_rx, b_fifo, b_cda}, 4'b1100);
    repeat (10) @(negedge clk);

    // Asynchronous reset in the middle of the FIFO pulse.
    user_mode = 1'b1;
    rx_dpa_locked = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (b_fifo) break;
    end
    check("fifo_pulse_seen", {3'b000, b_fifo}, 4'b0001);
    #2 rst = 1'b0;
    #1;
    check("async_rst_a", {a_pll, a_rx, a_fifo, a_cda}, 4'b1100);
    check("async_rst_b", {b_pll, b_rx, b_fifo, b_cda}, 4'b1100);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    check("replay_done_b", {b_pll, b_rx, b_fifo, b_cda}, 4'b0000);

    // Random input activity with occasional resets.
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) user_mode = ~user_mode;
      if ($urandom_range(0, 24) == 0) rx_locked = ~rx_locked;
      if ($urandom_range(0, 14) == 0) rx_dpa_locked = ~rx_dpa_locked;
      if ($urandom_range(0, 399) == 0) begin
        #1 rst = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
      end
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
